// File: rtl/fetch_queue_if.sv
// fetch_queue_if: ROM fetch handshake, redirect/stall controls and the
// decode-side head outputs of the instruction fetch queue.
// master = fetch queue, slave = ROM / pipeline environment.
interface fetch_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  o_chipEnable;
    logic [ADDR_WIDTH-1:0] o_romAddr;
    logic                  i_romAck;
    logic [INST_WIDTH-1:0] i_romInst;
    logic                  i_redirect;
    logic [ADDR_WIDTH-1:0] i_redirectPc;
    logic                  i_stall;
    logic                  o_valid;
    logic [ADDR_WIDTH-1:0] o_pc;
    logic [INST_WIDTH-1:0] o_inst;
    logic [CNT_W-1:0]      o_count;

    modport master (
        output o_chipEnable, o_romAddr, o_valid, o_pc, o_inst, o_count,
        input  i_romAck, i_romInst, i_redirect, i_redirectPc, i_stall
    );

    modport slave (
        input  o_chipEnable, o_romAddr, o_valid, o_pc, o_inst, o_count,
        output i_romAck, i_romInst, i_redirect, i_redirectPc, i_stall
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential-PC instruction fetch front end with a DEPTH-entry
// {pc, inst} queue toward decode. Redirect flushes the queue and restarts
// fetch at the target. Optional feature macro: FETCH_BYPASS_EN (when defined,
// a fetch into an empty queue is presented to decode in the same cycle).
module fetch_queue #(
    parameter int                   ADDR_WIDTH = 32,
    parameter int                   INST_WIDTH = 32,
    parameter int                   DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0,
    parameter int                   PC_STEP    = 4
) (
    input  logic            clk,
    input  logic            rst,
    fetch_queue_if.master   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] fpc_r;
    logic [ADDR_WIDTH-1:0] fpc_nxt_s;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_nxt_s;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_nxt_s;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [CNT_W-1:0]      remain_s;
    logic [ADDR_WIDTH-1:0] head_pc_r;
    logic [ADDR_WIDTH-1:0] head_pc_nxt_s;
    logic [INST_WIDTH-1:0] head_inst_r;
    logic [INST_WIDTH-1:0] head_inst_nxt_s;
    logic [ADDR_WIDTH-1:0] mem_pc_r   [DEPTH];
    logic [INST_WIDTH-1:0] mem_inst_r [DEPTH];

    logic ce_s;
    logic fire_s;
    logic byp_s;
    logic push_s;
    logic q_pop_s;
    logic valid_s;

    // Handshake decode: request enable, fire, bypass, push and queue pop.
    always_comb begin
        ce_s    = rst & (count_r < CNT_W'(DEPTH)) & ~bus.i_redirect;
        fire_s  = ce_s & bus.i_romAck;
`ifdef FETCH_BYPASS_EN
        byp_s   = fire_s & (count_r == '0);
`else
        byp_s   = 1'b0;
`endif
        valid_s = (count_r != '0) | byp_s;
        // A bypassed word consumed directly by decode is never stored.
        push_s  = fire_s & ~(byp_s & ~bus.i_stall);
        q_pop_s = (count_r != '0) & ~bus.i_stall & ~bus.i_redirect;
    end

    // Next-state for fetch PC, pointers, occupancy and registered head.
    always_comb begin
        fpc_nxt_s       = fpc_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        wr_ptr_nxt_s    = wr_ptr_r;
        count_nxt_s     = count_r;
        head_pc_nxt_s   = head_pc_r;
        head_inst_nxt_s = head_inst_r;
        remain_s        = count_r - {{(CNT_W-1){1'b0}}, q_pop_s};
        if (bus.i_redirect) begin
            fpc_nxt_s    = bus.i_redirectPc;
            rd_ptr_nxt_s = '0;
            wr_ptr_nxt_s = '0;
            count_nxt_s  = '0;
        end else begin
            if (fire_s) begin
                fpc_nxt_s = fpc_r + ADDR_WIDTH'(PC_STEP);
            end else begin
                fpc_nxt_s = fpc_r;
            end
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (q_pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            count_nxt_s = remain_s + {{(CNT_W-1){1'b0}}, push_s};
            // Head register tracks the entry that will sit at the read pointer;
            // when everything older is gone, it is the word being pushed now.
            if (count_nxt_s == '0) begin
                head_pc_nxt_s   = head_pc_r;
                head_inst_nxt_s = head_inst_r;
            end else if (remain_s == '0) begin
                head_pc_nxt_s   = fpc_r;
                head_inst_nxt_s = bus.i_romInst;
            end else begin
                head_pc_nxt_s   = mem_pc_r[rd_ptr_nxt_s];
                head_inst_nxt_s = mem_inst_r[rd_ptr_nxt_s];
            end
        end
    end

    // Control state and head registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_r       <= RESET_PC;
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            head_pc_r   <= '0;
            head_inst_r <= '0;
        end else begin
            fpc_r       <= fpc_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            count_r     <= count_nxt_s;
            head_pc_r   <= head_pc_nxt_s;
            head_inst_r <= head_inst_nxt_s;
        end
    end

    // Queue storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]   <= fpc_r;
            mem_inst_r[wr_ptr_r] <= bus.i_romInst;
        end
    end

    // Output drive; bypass presents the in-flight word when the queue is empty.
    always_comb begin
        bus.o_chipEnable = ce_s;
        bus.o_romAddr    = fpc_r;
        bus.o_count      = count_r;
        bus.o_valid      = valid_s;
        if (byp_s) begin
            bus.o_pc   = fpc_r;
            bus.o_inst = bus.i_romInst;
        end else begin
            bus.o_pc   = head_pc_r;
            bus.o_inst = head_inst_r;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized stimulus against a queue-based reference model
// of the fetch front end (DEPTH=4, RESET_PC=0, PC_STEP=4).
module tb_fetch_queue;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam int STEP  = 4;
    localparam logic [AW-1:0] RPC = 32'h0000_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [AW-1:0] fpc_m;
    logic [AW-1:0] q_pc[$];

    fetch_queue_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH),
        .RESET_PC(RPC), .PC_STEP(STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM contents: a fixed scrambling of the address.
    function automatic logic [IW-1:0] rom_f(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    assign bus.i_romInst = rom_f(bus.o_romAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check after settling, advance model, wait for next negedge.
    task automatic step(input logic ack, input logic stall, input logic redir, input logic [AW-1:0] rpc);
        logic exp_ce;
        logic fire;
        logic byp;
        logic exp_valid;
        logic [AW-1:0] exp_pc;
        bus.i_romAck     = ack;
        bus.i_stall      = stall;
        bus.i_redirect   = redir;
        bus.i_redirectPc = rpc;
        #1;
        exp_ce = rst && (q_pc.size() < DEPTH) && !redir;
        fire   = exp_ce && ack;
        byp    = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp    = fire && (q_pc.size() == 0);
`endif
        exp_valid = (q_pc.size() != 0) || byp;
        check_eq("chip_enable", 64'(bus.o_chipEnable), 64'(exp_ce));
        check_eq("rom_addr", 64'(bus.o_romAddr), 64'(fpc_m));
        check_eq("valid", 64'(bus.o_valid), 64'(exp_valid));
        check_eq("count", 64'(bus.o_count), 64'(q_pc.size()));
        if (exp_valid) begin
            exp_pc = byp ? fpc_m : q_pc[0];
            check_eq("head_pc", 64'(bus.o_pc), 64'(exp_pc));
            check_eq("head_inst", 64'(bus.o_inst), 64'(rom_f(exp_pc)));
        end
        if (redir) begin
            q_pc.delete();
            fpc_m = rpc;
        end else begin
            if (q_pc.size() != 0 && !stall) begin
                void'(q_pc.pop_front());
            end
            if (fire && !(byp && !stall)) begin
                q_pc.push_back(fpc_m);
            end
            if (fire) begin
                fpc_m = fpc_m + AW'(STEP);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ce"},    64'(bus.o_chipEnable), 64'd0);
        check_eq({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
        check_eq({tag, "_count"}, 64'(bus.o_count), 64'd0);
        check_eq({tag, "_pc"},    64'(bus.o_pc), 64'd0);
        check_eq({tag, "_inst"},  64'(bus.o_inst), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.i_romAck = 1'b0;
        bus.i_stall = 1'b0;
        bus.i_redirect = 1'b0;
        bus.i_redirectPc = '0;
        fpc_m = RPC;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Streaming: one fetch and one consume per cycle.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, '0);
        // Fill while stalled, then hold full.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);
        // Single pop from full; fetch resumes only the cycle after.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        // Redirect with ack active; then refetch from the target.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
        // Ack toggling 1,0,0,1.
        for (int r = 0; r < 4; r++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            step(1'b0, 1'b0, 1'b0, '0);
            step(1'b0, 1'b1, 1'b0, '0);
            step(1'b1, 1'b0, 1'b0, '0);
        end
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 19) == 0), AW'($urandom) & 32'hFFFF_FFFC);
        end
        // Asynchronous reset mid-stall.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);
        bus.i_stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q_pc.delete();
        fpc_m = RPC;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 29) == 0), AW'($urandom) & 32'hFFFF_FFFC);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
